// File: rtl/freq_meter_if.sv
`timescale 1ns/1ps
// freq_meter_if: control inputs and measurement results of the frequency meter.
// The slave side is the meter itself; the master side is whoever enables it and
// consumes the published counts.
interface freq_meter_if #(
  parameter int CNT_W = 24
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] freq;
  logic             valid;
  logic             overflow;
  logic             busy;

  modport slave (
    input  enable,
    input  sig_in,
    output freq,
    output valid,
    output overflow,
    output busy
  );

  modport master (
    output enable,
    output sig_in,
    input  freq,
    input  valid,
    input  overflow,
    input  busy
  );
endinterface

// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// freq_meter: counts rising edges of an asynchronous input over a gate window
// of exactly GATE_CYCLES clocks, then publishes the (saturating) count with a
// one-cycle valid pulse. One dead cycle (LATCH) separates consecutive windows,
// so in continuous mode results arrive every GATE_CYCLES+1 clocks.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 24
) (
  input  logic        clock,
  input  logic        reset,
  freq_meter_if.slave bus
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t            state_reg;
  logic              s1_reg;
  logic              s2_reg;
  logic              s3_reg;
  logic              rise;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [CNT_W-1:0]  edge_cnt_reg;
  logic              ovf_flag_reg;
  logic [CNT_W-1:0]  freq_reg;
  logic              valid_reg;
  logic              overflow_reg;

  // Two-flop synchroniser for the asynchronous input, plus one delay stage so
  // a rising edge becomes a single-cycle pulse in the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= bus.sig_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

  // Measurement sequencer: gate timing, saturating edge count, result publish.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      ovf_flag_reg <= 1'b0;
      freq_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      // valid is a pulse: only the LATCH exit raises it for one cycle.
      valid_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          gate_cnt_reg <= '0;
          edge_cnt_reg <= '0;
          ovf_flag_reg <= 1'b0;
          if (bus.enable) begin
            state_reg <= GATE;
          end
        end
        GATE: begin
          if (!bus.enable) begin
            // Abort: the partial count is thrown away, last result is kept.
            state_reg    <= IDLE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            ovf_flag_reg <= 1'b0;
          end else begin
            // A rise in the final gate cycle still belongs to this window.
            if (rise) begin
              if (edge_cnt_reg == CNT_MAX) begin
                ovf_flag_reg <= 1'b1;
              end else begin
                edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
              end
            end
            if (gate_cnt_reg == GATE_LAST) begin
              state_reg    <= LATCH;
              gate_cnt_reg <= '0;
            end else begin
              gate_cnt_reg <= gate_cnt_reg + GATE_W'(1);
            end
          end
        end
        LATCH: begin
          // Dead cycle: rises here are dropped. The result is always
          // published, whatever enable does in this cycle.
          freq_reg     <= edge_cnt_reg;
          overflow_reg <= ovf_flag_reg;
          valid_reg    <= 1'b1;
          gate_cnt_reg <= '0;
          edge_cnt_reg <= '0;
          ovf_flag_reg <= 1'b0;
          state_reg    <= bus.enable ? GATE : IDLE;
        end
        default: begin
          state_reg    <= IDLE;
          gate_cnt_reg <= '0;
          edge_cnt_reg <= '0;
          ovf_flag_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freq     = freq_reg;
  assign bus.valid    = valid_reg;
  assign bus.overflow = overflow_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
// tb_freq_meter: two meters (24-bit and 3-bit counters, 100-cycle gate) share
// the same enable/sig_in. A window-level model predicts every output on every
// cycle; directed scenarios add hand-computed literal expectations.
module tb_freq_meter;

  localparam int GATE = 100;
  localparam int WA   = 24;
  localparam int WB   = 3;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic sig_in;

  freq_meter_if #(.CNT_W(WA)) bus_a ();
  freq_meter_if #(.CNT_W(WB)) bus_b ();

  assign bus_a.enable = enable;
  assign bus_a.sig_in = sig_in;
  assign bus_b.enable = enable;
  assign bus_b.sig_in = sig_in;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(WA)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(WB)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic longint sat(input longint raw, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  // ---------------- stimulus source for sig_in ----------------
  int mode      = 0;   // 0 = manual level, 1 = square wave, 2 = random bits
  int period    = 10;
  int density   = 50;
  bit man_level = 1'b0;

  initial begin : sig_driver
    int tick;
    tick   = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      tick++;
      case (mode)
        0:       sig_in = man_level;
        1:       sig_in = ((tick % period) < (period / 2));
        default: sig_in = ($urandom_range(0, 99) < density);
      endcase
    end
  end

  // ---------------- window-level reference model ----------------
  // Samples of sig_in taken at the last three clock edges (oldest first).
  // A rise is counted at edge k when the sample from k-2 is 1 and from k-3 is 0.
  bit     hist[$] = '{1'b0, 1'b0, 1'b0};
  bit     in_win  = 1'b0;   // a window (gate + latch) is in progress
  int     pos     = 0;      // gate edges already elapsed in the window
  longint cnt     = 0;      // raw (unsaturated) rises in the current window
  longint m_raw   = 0;      // raw count of the last published window
  bit     m_valid = 1'b0;

  always @(posedge clock or negedge reset) begin : model
    bit r;
    if (!reset) begin
      hist    = '{1'b0, 1'b0, 1'b0};
      in_win  = 1'b0;
      pos     = 0;
      cnt     = 0;
      m_raw   = 0;
      m_valid = 1'b0;
    end else begin
      r = hist[1] & ~hist[0];
      void'(hist.pop_front());
      hist.push_back(sig_in);
      m_valid = 1'b0;
      if (!in_win) begin
        if (enable) begin
          in_win = 1'b1;
          pos    = 0;
          cnt    = 0;
        end
      end else if (pos < GATE) begin
        if (!enable) in_win = 1'b0;
        else begin
          pos++;
          cnt += longint'(r);
        end
      end else begin
        m_valid = 1'b1;
        m_raw   = cnt;
        if (enable) begin
          pos = 0;
          cnt = 0;
        end else begin
          in_win = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clock) begin
    check("a_freq",     bus_a.freq,     sat(m_raw, WA));
    check("a_overflow", bus_a.overflow, (m_raw > sat(m_raw, WA)) ? 1 : 0);
    check("a_valid",    bus_a.valid,    m_valid);
    check("a_busy",     bus_a.busy,     in_win);
    check("b_freq",     bus_b.freq,     sat(m_raw, WB));
    check("b_overflow", bus_b.overflow, (m_raw > sat(m_raw, WB)) ? 1 : 0);
    check("b_valid",    bus_b.valid,    m_valid);
    check("b_busy",     bus_b.busy,     in_win);
    if (bus_a.valid)
      $display("publish t=%0t freq_a=%0d ovf_a=%0d freq_b=%0d ovf_b=%0d",
               $time, bus_a.freq, bus_a.overflow, bus_b.freq, bus_b.overflow);
  end

  // ---------------- helpers ----------------
  // Waits for the next valid on meter A; n = negedges waited (bounded).
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clock);
      if (bus_a.valid) begin
        n = i;
        return;
      end
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic async_reset_pulse();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed then random stimulus ----------------
  initial begin : main
    int n;
    int nv;
    reset     = 1'b0;
    enable    = 1'b0;
    mode      = 0;
    man_level = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_freq",  bus_a.freq, 0);
    check("rst_valid", bus_a.valid, 0);
    check("rst_ovf",   bus_a.overflow, 0);
    check("rst_busy",  bus_a.busy, 0);
    reset = 1'b1;

    // Square wave, period 10, continuous.
    mode   = 1;
    period = 10;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    wait_valid("t1a", n);
    check("t1_latency", n, 102);
    check("t1_freq", bus_a.freq, 10);
    check("t1_ovf", bus_a.overflow, 0);
    @(negedge clock);
    check("t1_pulse_width", bus_a.valid, 0);
    wait_valid("t1b", n);
    check("t1_period", n + 1, 101);
    check("t1_freq2", bus_a.freq, 10);

    // Period 4 saturates the 3-bit meter; then a quiet window clears it.
    period = 4;
    wait_valid("t2a", n);
    wait_valid("t2b", n);
    check("t2_freq_a", bus_a.freq, 25);
    check("t2_freq_b", bus_b.freq, 7);
    check("t2_ovf_b", bus_b.overflow, 1);
    mode      = 0;
    man_level = 1'b0;
    wait_valid("t2c", n);
    wait_valid("t2d", n);
    check("t2_quiet_freq_b", bus_b.freq, 0);
    check("t2_quiet_ovf_b", bus_b.overflow, 0);

    // Abort mid-gate after a freq=10 result, then a fresh window.
    mode   = 1;
    period = 10;
    wait_valid("t3a", n);
    wait_valid("t3b", n);
    check("t3_freq", bus_a.freq, 10);
    repeat (50) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("t3_busy_after_abort", bus_a.busy, 0);
    check("t3_freq_held", bus_a.freq, 10);
    nv = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (bus_a.valid) nv++;
    end
    check("t3_no_valid", nv, 0);
    enable = 1'b1;
    wait_valid("t3c", n);
    check("t3_fresh_latency", n, 102);
    check("t3_fresh_freq", bus_a.freq, 10);

    // Asynchronous reset in the middle of a gate.
    repeat (40) @(negedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("t4_freq", bus_a.freq, 0);
    check("t4_valid", bus_a.valid, 0);
    check("t4_ovf", bus_a.overflow, 0);
    check("t4_busy", bus_a.busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_valid("t4a", n);
    check("t4_first_latency", n, 102);
    wait_valid("t4b", n);
    check("t4_freq_after", bus_a.freq, 10);

    // Input held high: no edges.
    enable    = 1'b0;
    mode      = 0;
    man_level = 1'b1;
    repeat (10) @(negedge clock);
    enable = 1'b1;
    wait_valid("t5a", n);
    check("t5_held_high", bus_a.freq, 0);

    // One rise landing in the last gate cycle is counted.
    enable    = 1'b0;
    man_level = 1'b0;
    repeat (6) @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    repeat (97) @(posedge clock);
    @(negedge clock);
    man_level = 1'b1;
    wait_valid("t5b", n);
    check("t5_last_cycle_edge", bus_a.freq, 1);

    // One rise landing in the LATCH cycle is dropped.
    enable    = 1'b0;
    man_level = 1'b0;
    repeat (6) @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    repeat (98) @(posedge clock);
    @(negedge clock);
    man_level = 1'b1;
    wait_valid("t5c", n);
    check("t5_latch_edge_dropped", bus_a.freq, 0);

    // Randomised traffic: mixed waveforms, enable toggles, stray resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if ((i % 300) == 0) begin
        mode    = $urandom_range(0, 2);
        period  = $urandom_range(2, 12);
        density = $urandom_range(5, 95);
        man_level = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      if ($urandom_range(0, 1499) == 0) async_reset_pulse();
    end

    enable = 1'b0;
    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
